// File: rtl/bridge_io.sv
// bridge_io: data-side bus bridge between the single-cycle core and the data
// RAM / peripheral page (DIG seven-segment display, LEDs, switches). Address
// decode and the load-data mux are combinational. The peripheral registers,
// the switch synchronizer and the display scan engine are clocked here.
module bridge_io #(
  parameter int unsigned SCAN_DIV = 20000,
  parameter int unsigned DRAM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               we,
  output logic [31:0]        rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic [31:0]        dram_wdata,
  output logic               dram_we,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  output logic [23:0]        led,
  output logic [7:0]         seg_en,
  output logic [7:0]         seg
);

  localparam logic [9:0]  OFF_DIG = 10'h000;  // 0x000 >> 2
  localparam logic [9:0]  OFF_LED = 10'h018;  // 0x060 >> 2
  localparam logic [9:0]  OFF_SW  = 10'h01C;  // 0x070 >> 2
  localparam logic [19:0] CNT_MAX = 20'(SCAN_DIV - 1);

  logic        page;
  logic [9:0]  word_off;
  logic        sel_dig;
  logic        sel_led;
  logic        sel_sw;
  logic [31:0] dig_reg;
  logic [23:0] sw_s1;
  logic [23:0] sw_s2;
  logic [19:0] cnt;
  logic [2:0]  idx;
  logic        scan_tick;
  logic [3:0]  nibble;
  logic [6:0]  seg_code;
  logic        unused_addr;

  // Byte lanes are not decoded; peripherals only see word accesses.
  assign unused_addr = &{1'b0, addr[1:0]};

  // Address decode: peripheral page is the top 4 KiB of the address space.
  always_comb begin
    page     = (addr[31:12] == 20'hFFFFF);
    word_off = addr[11:2];
    sel_dig  = page && (word_off == OFF_DIG);
    sel_led  = page && (word_off == OFF_LED);
    sel_sw   = page && (word_off == OFF_SW);
  end

  // RAM side: pass-through with the write enable masked off on the page.
  always_comb begin
    dram_addr  = addr[DRAM_AW+1:2];
    dram_wdata = wdata;
    dram_we    = we & ~page;
  end

  // Load data mux; unmapped page offsets read as zero.
  always_comb begin
    rdata = '0;
    if (!page)        rdata = dram_rdata;
    else if (sel_dig) rdata = dig_reg;
    else if (sel_led) rdata = {8'h00, led};
    else if (sel_sw)  rdata = {8'h00, sw_s2};
  end

  // Peripheral output registers; reset wins over a concurrent store.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_reg <= '0;
      led     <= '0;
    end else if (we) begin
      if (sel_dig) dig_reg <= wdata;
      if (sel_led) led     <= wdata[23:0];
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  assign scan_tick = (cnt == CNT_MAX);

  // Scan divider: each digit stays selected for SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (scan_tick) begin
      cnt <= '0;
      idx <= idx + 3'd1;
    end else begin
      cnt <= cnt + 20'd1;
    end
  end

  // Select the current digit's nibble and encode it for an active-low display.
  always_comb begin
    nibble   = 4'(dig_reg >> {idx, 2'b00});
    seg_code = 7'h7F;
    case (nibble)
      4'h0: seg_code = 7'h40;
      4'h1: seg_code = 7'h79;
      4'h2: seg_code = 7'h24;
      4'h3: seg_code = 7'h30;
      4'h4: seg_code = 7'h19;
      4'h5: seg_code = 7'h12;
      4'h6: seg_code = 7'h02;
      4'h7: seg_code = 7'h78;
      4'h8: seg_code = 7'h00;
      4'h9: seg_code = 7'h10;
      4'hA: seg_code = 7'h08;
      4'hB: seg_code = 7'h03;
      4'hC: seg_code = 7'h46;
      4'hD: seg_code = 7'h21;
      4'hE: seg_code = 7'h06;
      4'hF: seg_code = 7'h0E;
      default: seg_code = 7'h7F;
    endcase
  end

  // Registered display drive; samples the pre-edge idx and dig_reg, so a DIG
  // store coinciding with a digit advance shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_en <= 8'hFE;
      seg    <= 8'hC0;
    end else begin
      seg_en <= ~(8'b1 << idx);
      seg    <= {1'b1, seg_code};
    end
  end

endmodule

// File: tb/tb_bridge_io.sv
// Directed bench for bridge_io: RAM pass-through, LED/DIG/SW registers,
// switch synchronizer latency, scan sequence, reset and store/advance collision.
module tb_bridge_io;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] dram_rdata;
  logic [23:0] sw;

  logic [31:0] rdata,   rdata_b;
  logic [13:0] dram_addr, dram_addr_b;
  logic [31:0] dram_wdata, dram_wdata_b;
  logic        dram_we, dram_we_b;
  logic [23:0] led, led_b;
  logic [7:0]  seg_en, seg_en_b;
  logic [7:0]  seg, seg_b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] seg_tab [8];
  logic [7:0] one8;

  always #5 clk = ~clk;

  bridge_io #(.SCAN_DIV(2), .DRAM_AW(14)) u_a (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_we(dram_we), .dram_rdata(dram_rdata), .sw(sw), .led(led),
    .seg_en(seg_en), .seg(seg)
  );

  bridge_io #(.SCAN_DIV(1), .DRAM_AW(14)) u_b (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata_b), .dram_addr(dram_addr_b), .dram_wdata(dram_wdata_b),
    .dram_we(dram_we_b), .dram_rdata(dram_rdata), .sw(sw), .led(led_b),
    .seg_en(seg_en_b), .seg(seg_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
    one8 = 8'd1;

    // Reset, with combinational paths live during reset
    rst = 1'b1; we = 1'b1; addr = 32'h0000_0010; wdata = 32'h0;
    dram_rdata = 32'hCAFE_F00D; sw = 24'h0;
    #1;
    check("rst_rdata_dram", rdata, 32'hCAFE_F00D);
    check("rst_dram_we", {31'b0, dram_we}, 32'h1);
    we = 1'b0;
    step(); step();
    check("rst_seg_en", {24'b0, seg_en}, 32'hFE);
    check("rst_seg", {24'b0, seg}, 32'hC0);
    check("rst_led", {8'b0, led}, 32'h0);
    addr = 32'hFFFF_F000; #1;
    check("rst_dig", rdata, 32'h0);
    rst = 1'b0;

    // DRAM path
    addr = 32'h0000_0010; wdata = 32'hDEAD_BEEF; we = 1'b1; #1;
    check("dram_we", {31'b0, dram_we}, 32'h1);
    check("dram_addr", {18'b0, dram_addr}, 32'h4);
    check("dram_wdata", dram_wdata, 32'hDEAD_BEEF);
    we = 1'b0; dram_rdata = 32'h1234_5678; #1;
    check("dram_rdata", rdata, 32'h1234_5678);
    check("dram_we_off", {31'b0, dram_we}, 32'h0);

    // LED write/read
    addr = 32'hFFFF_F060; wdata = 32'hFFAB_CDEF; we = 1'b1; #1;
    check("led_dram_we", {31'b0, dram_we}, 32'h0);
    step();
    we = 1'b0; #1;
    check("led_reg", {8'b0, led}, 32'h00AB_CDEF);
    check("led_read", rdata, 32'h00AB_CDEF);

    // Switch synchronizer: visible after the second edge
    addr = 32'hFFFF_F070; sw = 24'h5A5A5A; #1;
    check("sw_e0", rdata, 32'h0);
    step();
    check("sw_e1", rdata, 32'h0);
    step();
    check("sw_e2", rdata, 32'h005A_5A5A);

    // Scan sequence, SCAN_DIV=2, starting from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    addr = 32'hFFFF_F000; wdata = 32'h7654_3210; we = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 1) begin
        we = 1'b0; #1;
        check("dig_read", rdata, 32'h7654_3210);
      end
      check($sformatf("scan_en_%0d", k), {24'b0, seg_en},
            {24'b0, ~(one8 << (((k - 1) / 2) % 8))});
      check($sformatf("scan_seg_%0d", k), {24'b0, seg},
            {24'b0, seg_tab[((k - 1) / 2) % 8]});
    end

    // Unmapped offset: no effect, reads zero
    addr = 32'hFFFF_F100; wdata = 32'hFFFF_FFFF; we = 1'b1; #1;
    check("unm_dram_we", {31'b0, dram_we}, 32'h0);
    step();
    we = 1'b0; #1;
    check("unm_read", rdata, 32'h0);
    addr = 32'hFFFF_F000; #1;
    check("unm_dig_kept", rdata, 32'h7654_3210);
    check("unm_led_kept", {8'b0, led}, 32'h0);

    // Load LEDs, idle to idx=5, then reset with a concurrent LED store
    addr = 32'hFFFF_F060; wdata = 32'h0012_3456; we = 1'b1;
    step();
    we = 1'b0;
    check("led2", {8'b0, led}, 32'h0012_3456);
    for (int k = 0; k < 7; k++) step();
    rst = 1'b1; we = 1'b1; wdata = 32'h00FF_FFFF;
    step();
    rst = 1'b0; we = 1'b0;
    check("mid_rst_led", {8'b0, led}, 32'h0);
    check("mid_rst_seg_en", {24'b0, seg_en}, 32'hFE);
    addr = 32'hFFFF_F000; #1;
    check("mid_rst_dig", rdata, 32'h0);
    step();
    check("post_rst_en1", {24'b0, seg_en}, 32'hFE);
    check("post_rst_seg1", {24'b0, seg}, 32'hC0);
    step();
    check("post_rst_en2", {24'b0, seg_en}, 32'hFE);
    step();
    check("post_rst_en3", {24'b0, seg_en}, 32'hFD);
    check("post_rst_seg3", {24'b0, seg}, 32'hC0);

    // Store/advance collision on the SCAN_DIV=1 instance
    rst = 1'b1; step(); rst = 1'b0;
    check("b_rst_en", {24'b0, seg_en_b}, 32'hFE);
    addr = 32'hFFFF_F000; wdata = 32'hFFFF_FFFF; we = 1'b1;
    step();
    we = 1'b0;
    check("coll_en1", {24'b0, seg_en_b}, 32'hFE);
    check("coll_seg1", {24'b0, seg_b}, 32'hC0);
    step();
    check("coll_en2", {24'b0, seg_en_b}, 32'hFD);
    check("coll_seg2", {24'b0, seg_b}, 32'h8E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
